// File: rtl/fifo_sync_param_2_if.sv
// Bundle of producer/consumer signals for the single-clock elastic FIFO.
//
// Handshake semantics (both sides are sampled on the rising clock edge):
//   write side : w_en is a request. It is accepted on an edge only when w_full
//                was low before that edge. A request made while w_full is high
//                is dropped and raises the sticky overflow flag.
//   read side  : r_en is a request, or the pop of the head word in FWFT mode.
//                It is accepted on an edge only when r_empty was low before
//                that edge. A request made while r_empty is high is ignored
//                and raises the sticky underflow flag.
//   rdata is meaningful only while r_valid is high.
interface fifo_sync_param_2_if #(
    parameter int MEMORY_WIDTH = 8,
    parameter int ADDRESS_SIZE = 4
);
    logic                    w_en;
    logic [MEMORY_WIDTH-1:0] wdata;
    logic                    r_en;
    logic                    err_clr;
    logic [MEMORY_WIDTH-1:0] rdata;
    logic                    r_valid;
    logic                    w_full;
    logic                    r_empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [ADDRESS_SIZE:0]   count;
    logic                    overflow;
    logic                    underflow;

    // Producer/consumer side: drives requests and observes status.
    modport master (
        output w_en, wdata, r_en, err_clr,
        input  rdata, r_valid, w_full, r_empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  w_en, wdata, r_en, err_clr,
        output rdata, r_valid, w_full, r_empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param_2.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost
// flags, sticky overflow/underflow errors and a selectable read mode
// (registered read or first-word-fall-through).
module fifo_sync_param_2 #(
    parameter int MEMORY_WIDTH    = 8,
    parameter int ADDRESS_SIZE    = 4,
    parameter int ALMOST_FULL_TH  = 12,
    parameter int ALMOST_EMPTY_TH = 4,
    parameter int FWFT            = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_sync_param_2_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam int CW    = ADDRESS_SIZE + 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_CNT    = CW'(ALMOST_EMPTY_TH);

    // Reject illegal parameter combinations at elaboration time.
    if (MEMORY_WIDTH < 1) begin : g_bad_width
        $error("fifo_sync_param_2: MEMORY_WIDTH must be >= 1");
    end
    if (ADDRESS_SIZE < 1) begin : g_bad_addr
        $error("fifo_sync_param_2: ADDRESS_SIZE must be >= 1");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af_th
        $error("fifo_sync_param_2: ALMOST_FULL_TH must be in 1..DEPTH");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae_th
        $error("fifo_sync_param_2: ALMOST_EMPTY_TH must be in 0..DEPTH-1");
    end

    // Storage; contents are deliberately not reset.
    logic [MEMORY_WIDTH-1:0] mem [DEPTH];

    // Binary pointers one bit wider than the address so full and empty
    // are distinguishable; they wrap modulo 2*DEPTH.
    logic [CW-1:0] w_ptr;
    logic [CW-1:0] r_ptr;
    logic [CW-1:0] w_ptr_nxt;
    logic [CW-1:0] r_ptr_nxt;
    logic [CW-1:0] count_nxt;

    // Registered occupancy and status flags.
    logic [CW-1:0] count_q;
    logic          full_q;
    logic          empty_q;
    logic          af_q;
    logic          ae_q;
    logic          ovf_q;
    logic          udf_q;

    logic          wr_ok;
    logic          rd_ok;

    logic [ADDRESS_SIZE-1:0] w_addr;
    logic [ADDRESS_SIZE-1:0] r_addr;

    logic [MEMORY_WIDTH-1:0] rdata_int;
    logic                    r_valid_int;

    assign w_addr = w_ptr[ADDRESS_SIZE-1:0];
    assign r_addr = r_ptr[ADDRESS_SIZE-1:0];

    // Acceptance uses the registered flags, so a full FIFO still accepts a
    // read (and drops the write) and an empty one still accepts a write.
    assign wr_ok = bus.w_en & ~full_q;
    assign rd_ok = bus.r_en & ~empty_q;

    // Next pointers and the occupancy they imply.
    always_comb begin
        w_ptr_nxt = w_ptr;
        r_ptr_nxt = r_ptr;
        if (wr_ok) begin
            w_ptr_nxt = w_ptr + CW'(1);
        end
        if (rd_ok) begin
            r_ptr_nxt = r_ptr + CW'(1);
        end
        count_nxt = w_ptr_nxt - r_ptr_nxt;
    end

    // Pointers, count and flags; flags are decoded from the next count and
    // registered so they only ever change on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            w_ptr   <= w_ptr_nxt;
            r_ptr   <= r_ptr_nxt;
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_CNT);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_CNT);
            ae_q    <= (count_nxt <= AE_CNT);
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.w_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end
            if (bus.r_en && empty_q) begin
                udf_q <= 1'b1;
            end else if (bus.err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_addr] <= bus.wdata;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented combinationally whenever the FIFO holds data;
        // it reads as zero while empty so rdata is defined after reset.
        always_comb begin
            rdata_int   = '0;
            r_valid_int = ~empty_q;
            if (!empty_q) begin
                rdata_int = mem[r_addr];
            end
        end
    end else begin : g_reg
        logic [MEMORY_WIDTH-1:0] rdata_q;
        logic                    r_valid_q;

        // Registered read: data lands one edge after an accepted read and
        // r_valid marks that single cycle; rdata otherwise holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q   <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_valid_q <= rd_ok;
                if (rd_ok) begin
                    rdata_q <= mem[r_addr];
                end
            end
        end

        assign rdata_int   = rdata_q;
        assign r_valid_int = r_valid_q;
    end

    assign bus.rdata        = rdata_int;
    assign bus.r_valid      = r_valid_int;
    assign bus.w_full       = full_q;
    assign bus.r_empty      = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param_2.sv
// Bench for fifo_sync_param_2: one registered-read instance and one FWFT
// instance, each checked against a queue-based model of the FIFO rules.
module tb_fifo_sync_param_2;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    fifo_sync_param_2_if #(.MEMORY_WIDTH(8), .ADDRESS_SIZE(4)) bus0 ();
    fifo_sync_param_2_if #(.MEMORY_WIDTH(8), .ADDRESS_SIZE(4)) bus1 ();

    fifo_sync_param_2 #(
        .MEMORY_WIDTH(8), .ADDRESS_SIZE(4), .ALMOST_FULL_TH(12),
        .ALMOST_EMPTY_TH(4), .FWFT(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    fifo_sync_param_2 #(
        .MEMORY_WIDTH(8), .ADDRESS_SIZE(4), .ALMOST_FULL_TH(12),
        .ALMOST_EMPTY_TH(4), .FWFT(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference models
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       ovf0 = 1'b0, udf0 = 1'b0, ovf1 = 1'b0, udf1 = 1'b0;
    logic [7:0] exp_rdata0 = 8'h00;
    logic       exp_rvalid0 = 1'b0;

    // Driver for the registered-read instance: apply one cycle, advance model.
    task automatic step0(input logic we, input logic [7:0] wd, input logic re, input logic ec);
        bit wr_ok, rd_ok;
        bus0.w_en = we; bus0.wdata = wd; bus0.r_en = re; bus0.err_clr = ec;
        @(posedge clk);
        wr_ok = we && (q0.size() < DEPTH);
        rd_ok = re && (q0.size() > 0);
        if (we && q0.size() == DEPTH) ovf0 = 1'b1; else if (ec) ovf0 = 1'b0;
        if (re && q0.size() == 0) udf0 = 1'b1; else if (ec) udf0 = 1'b0;
        exp_rvalid0 = rd_ok;
        if (rd_ok) exp_rdata0 = q0.pop_front();
        if (wr_ok) q0.push_back(wd);
        #1;
        bus0.w_en = 1'b0; bus0.r_en = 1'b0; bus0.err_clr = 1'b0;
    endtask

    // Driver for the FWFT instance.
    task automatic step1(input logic we, input logic [7:0] wd, input logic re, input logic ec);
        bit wr_ok, rd_ok;
        bus1.w_en = we; bus1.wdata = wd; bus1.r_en = re; bus1.err_clr = ec;
        @(posedge clk);
        wr_ok = we && (q1.size() < DEPTH);
        rd_ok = re && (q1.size() > 0);
        if (we && q1.size() == DEPTH) ovf1 = 1'b1; else if (ec) ovf1 = 1'b0;
        if (re && q1.size() == 0) udf1 = 1'b1; else if (ec) udf1 = 1'b0;
        if (rd_ok) void'(q1.pop_front());
        if (wr_ok) q1.push_back(wd);
        #1;
        bus1.w_en = 1'b0; bus1.r_en = 1'b0; bus1.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        step0(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step0(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step0(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (bus0.underflow !== 1'b1) begin bad++; $display("FAIL pre_reset_udf: got %0b want 1", bus0.underflow); end
        total++; if (bus0.rdata !== 8'h10 || bus0.r_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_rdata: got %0h/%0b want 10/1", bus0.rdata, bus0.r_valid); end
        for (int i = 0; i < 2; i++) step1(1'b1, 8'h5A, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        q0.delete(); q1.delete();
        ovf0 = 0; udf0 = 0; ovf1 = 0; udf1 = 0; exp_rdata0 = 8'h00; exp_rvalid0 = 0;
        total++; if (bus0.r_empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %0b want 1", bus0.r_empty); end
        total++; if (bus0.count !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus0.count); end
        total++; if (bus0.r_valid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %0b want 0", bus0.r_valid); end
        total++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin bad++; $display("FAIL rst_errs: got %0b%0b want 00", bus0.overflow, bus0.underflow); end
        total++; if (bus0.rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %0h want 0", bus0.rdata); end
        total++; if (bus0.w_full !== 1'b0 || bus0.almost_full !== 1'b0 || bus0.almost_empty !== 1'b1) begin bad++; $display("FAIL rst_flags: got full=%0b af=%0b ae=%0b want 0 0 1", bus0.w_full, bus0.almost_full, bus0.almost_empty); end
        total++; if (bus1.r_valid !== 1'b0 || bus1.rdata !== 8'h00 || bus1.count !== 5'd0) begin bad++; $display("FAIL rst_fwft: got v=%0b d=%0h c=%0d want 0 0 0", bus1.r_valid, bus1.rdata, bus1.count); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step0(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (bus0.underflow !== 1'b1 || bus0.r_valid !== 1'b0) begin bad++; $display("FAIL post_rst_empty_read: got udf=%0b v=%0b want 1 0", bus0.underflow, bus0.r_valid); end
        step0(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (bus0.underflow !== 1'b0) begin bad++; $display("FAIL post_rst_clr: got %0b want 0", bus0.underflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step0(1'b1, 8'(i), 1'b0, 1'b0);
            total++; if (bus0.count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count: got %0d want %0d", bus0.count, i + 1); end
            total++; if (bus0.almost_full !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_af: got %0b at count %0d", bus0.almost_full, i + 1); end
            total++; if (bus0.w_full !== (i + 1 == DEPTH)) begin bad++; $display("FAIL fill_full: got %0b at count %0d", bus0.w_full, i + 1); end
        end
        step0(1'b1, 8'h77, 1'b0, 1'b0);
        total++; if (bus0.overflow !== 1'b1 || bus0.count !== 5'd16) begin bad++; $display("FAIL fill_overflow: got ovf=%0b c=%0d want 1 16", bus0.overflow, bus0.count); end
        for (int i = 0; i < DEPTH; i++) begin
            step0(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (bus0.r_valid !== 1'b1 || bus0.rdata !== 8'(i)) begin bad++; $display("FAIL drain_data: got %0h/%0b want %0h/1", bus0.rdata, bus0.r_valid, i); end
            total++; if (bus0.count !== 5'(15 - i) || bus0.almost_empty !== (15 - i <= 4)) begin bad++; $display("FAIL drain_count: got c=%0d ae=%0b want %0d", bus0.count, bus0.almost_empty, 15 - i); end
        end
        step0(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (bus0.r_empty !== 1'b1 || bus0.r_valid !== 1'b0 || bus0.rdata !== 8'h0F) begin bad++; $display("FAIL drain_idle: got e=%0b v=%0b d=%0h want 1 0 f", bus0.r_empty, bus0.r_valid, bus0.rdata); end
        total++; if (bus0.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", bus0.overflow); end
        step0(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (bus0.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %0b want 0", bus0.overflow); end
    endtask

    task automatic test_full_rw();
        logic [7:0] first;
        first = 8'($urandom_range(0, 255));
        step0(1'b1, first, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) step0(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        step0(1'b1, 8'hEE, 1'b1, 1'b0);
        total++; if (bus0.count !== 5'd15 || bus0.overflow !== 1'b1) begin bad++; $display("FAIL full_rw: got c=%0d ovf=%0b want 15 1", bus0.count, bus0.overflow); end
        total++; if (bus0.rdata !== first || bus0.r_valid !== 1'b1) begin bad++; $display("FAIL full_rw_pop: got %0h want %0h", bus0.rdata, first); end
        for (int i = 0; i < 15; i++) begin
            step0(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (bus0.rdata !== exp_rdata0) begin bad++; $display("FAIL full_rw_drain: got %0h want %0h", bus0.rdata, exp_rdata0); end
        end
        total++; if (bus0.r_empty !== 1'b1) begin bad++; $display("FAIL full_rw_empty: got %0b want 1", bus0.r_empty); end
        step0(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_empty_rw();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        step0(1'b1, d, 1'b1, 1'b0);
        total++; if (bus0.count !== 5'd1 || bus0.underflow !== 1'b1 || bus0.r_valid !== 1'b0 || bus0.r_empty !== 1'b0) begin bad++; $display("FAIL empty_rw: got c=%0d udf=%0b v=%0b e=%0b want 1 1 0 0", bus0.count, bus0.underflow, bus0.r_valid, bus0.r_empty); end
        step0(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (bus0.underflow !== 1'b0 || bus0.overflow !== 1'b0) begin bad++; $display("FAIL err_clr: got udf=%0b ovf=%0b want 0 0", bus0.underflow, bus0.overflow); end
        step0(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (bus0.rdata !== d) begin bad++; $display("FAIL empty_rw_data: got %0h want %0h", bus0.rdata, d); end
        step0(1'b0, 8'h00, 1'b1, 1'b1);
        total++; if (bus0.underflow !== 1'b1) begin bad++; $display("FAIL set_wins: got %0b want 1", bus0.underflow); end
        step0(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (bus0.underflow !== 1'b0) begin bad++; $display("FAIL set_wins_clr: got %0b want 0", bus0.underflow); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) step0(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step0(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            total++; if (bus0.count !== 5'd8 || bus0.r_valid !== 1'b1 || bus0.rdata !== exp_rdata0) begin bad++; $display("FAIL stream: got c=%0d v=%0b d=%0h want 8 1 %0h", bus0.count, bus0.r_valid, bus0.rdata, exp_rdata0); end
        end
        for (int i = 0; i < 300; i++) begin
            step0(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            total++; if (bus0.count !== 5'(q0.size()) || bus0.w_full !== (q0.size() == DEPTH) || bus0.r_empty !== (q0.size() == 0)) begin bad++; $display("FAIL rand_count: got c=%0d f=%0b e=%0b want %0d", bus0.count, bus0.w_full, bus0.r_empty, q0.size()); end
            total++; if (bus0.almost_full !== (q0.size() >= 12) || bus0.almost_empty !== (q0.size() <= 4)) begin bad++; $display("FAIL rand_almost: got af=%0b ae=%0b at count %0d", bus0.almost_full, bus0.almost_empty, q0.size()); end
            total++; if (bus0.overflow !== ovf0 || bus0.underflow !== udf0) begin bad++; $display("FAIL rand_errs: got %0b%0b want %0b%0b", bus0.overflow, bus0.underflow, ovf0, udf0); end
            total++; if (bus0.r_valid !== exp_rvalid0 || bus0.rdata !== exp_rdata0) begin bad++; $display("FAIL rand_read: got %0h/%0b want %0h/%0b", bus0.rdata, bus0.r_valid, exp_rdata0, exp_rvalid0); end
        end
        for (int i = 0; i < DEPTH && q0.size() > 0; i++) step0(1'b0, 8'h00, 1'b1, 1'b0);
        step0(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_fwft();
        step1(1'b1, 8'hA5, 1'b0, 1'b0);
        total++; if (bus1.rdata !== 8'hA5 || bus1.r_valid !== 1'b1 || bus1.r_empty !== 1'b0) begin bad++; $display("FAIL fwft_head: got %0h/%0b/%0b want a5/1/0", bus1.rdata, bus1.r_valid, bus1.r_empty); end
        step1(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (bus1.r_empty !== 1'b1 || bus1.r_valid !== 1'b0) begin bad++; $display("FAIL fwft_pop: got e=%0b v=%0b want 1 0", bus1.r_empty, bus1.r_valid); end
        for (int i = 0; i < 120; i++) begin
            step1(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            total++; if (bus1.r_valid !== (q1.size() > 0) || bus1.count !== 5'(q1.size())) begin bad++; $display("FAIL fwft_rand_state: got v=%0b c=%0d want %0d", bus1.r_valid, bus1.count, q1.size()); end
            if (q1.size() > 0) begin
                total++; if (bus1.rdata !== q1[0]) begin bad++; $display("FAIL fwft_rand_data: got %0h want %0h", bus1.rdata, q1[0]); end
            end
            total++; if (bus1.overflow !== ovf1 || bus1.underflow !== udf1) begin bad++; $display("FAIL fwft_rand_errs: got %0b%0b want %0b%0b", bus1.overflow, bus1.underflow, ovf1, udf1); end
        end
    endtask

    initial begin
        bus0.w_en = 0; bus0.wdata = 0; bus0.r_en = 0; bus0.err_clr = 0;
        bus1.w_en = 0; bus1.wdata = 0; bus1.r_en = 0; bus1.err_clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        test_reset();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_stream();
        test_fwft();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
